count_sampler: RTL and testbench

COUNT_SAMPLER -- requirements
Module: count_sampler

---
 rtl/count_sampler.sv | 66 ++++++
 tb/tb_count_sampler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/count_sampler.sv
// count_sampler: debounced sampler of an asynchronous 3-bit ripple counter with valid/ready output.
// Define COUNT_SAMPLER_WRAP_EN to enable epoch counting and wrap_pulse.
module count_sampler #(
  parameter int STABLE_CYCLES = 2,
  parameter int EPOCH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         cnt_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EPOCH_W+2:0] out_count,
  output logic               wrap_pulse,
  output logic               overrun,
  input  logic               clr_overrun
);
  logic [2:0] sync1_q, sync2_q, cand_q, acc_q;
  logic [3:0] stab_q;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W+2:0] out_count_q;
  logic out_valid_q, wrap_q, overrun_q, accept, wrap;
  assign accept = stab_q == 4'(STABLE_CYCLES) && cand_q != acc_q;
`ifdef COUNT_SAMPLER_WRAP_EN
  assign wrap = accept && cand_q < acc_q;
`else
  assign wrap = 1'b0;
`endif
  // without wrap tracking the epoch never leaves its reset value of 0
  assign epoch_d = epoch_q + EPOCH_W'(wrap);
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      acc_q       <= '0;
      stab_q      <= '0;
      epoch_q     <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q <= cnt_in;
      sync2_q <= sync1_q;
      if (sync2_q == cand_q) begin
        stab_q <= stab_q == 4'(STABLE_CYCLES) ? stab_q : stab_q + 4'd1;
      end else begin
        cand_q <= sync2_q;
        stab_q <= 4'd1;
      end
      if (accept) begin
        acc_q       <= cand_q;
        out_count_q <= {epoch_d, cand_q};
      end
      epoch_q     <= epoch_d;
      wrap_q      <= wrap;
      out_valid_q <= accept || (out_valid_q && !out_ready);
      // a set on the same edge as a clear wins
      overrun_q   <= (accept && out_valid_q && !out_ready) || (overrun_q && !clr_overrun);
    end
  end
  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign wrap_pulse = wrap_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_count_sampler.sv
// tb_count_sampler: vector table, directed wrap sweep and random stimulus against a sample-history model.
module tb_count_sampler;
  localparam int S = 2;
`ifdef COUNT_SAMPLER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0, clr_overrun = 1'b0;
  logic [2:0] cnt_in = '0;
  logic out_valid, wrap_pulse, overrun;
  logic [10:0] out_count;
  int checks = 0, errors = 0;

  count_sampler #(.STABLE_CYCLES(S), .EPOCH_W(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .wrap_pulse(wrap_pulse), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // model: history of inputs applied since reset; a value is accepted once the
  // last S synchronized samples all equal it and it differs from the last accepted value
  int x[$];
  logic [2:0] m_acc;
  logic [7:0] m_epoch;
  logic [10:0] m_count;
  logic m_valid, m_wrap, m_orun;

  function automatic int samp(int i);
    return i >= 1 ? x[i-1] : 0;
  endfunction

  task automatic model(input logic r, input logic [2:0] c, input logic rdy, input logic clr);
    int n, v;
    bit ok, ev;
    if (r) begin
      x.delete();
      m_acc = 0; m_epoch = 0; m_count = 0; m_valid = 0; m_wrap = 0; m_orun = 0;
      return;
    end
    n = x.size();
    ok = (n - 1 - S) >= -1;
    v = samp(n - 2);
    if (ok) for (int i = n - 2; i >= n - 1 - S; i--) if (samp(i) != v) ok = 0;
    ev = ok && v != int'(m_acc);
    m_wrap = WRAP_EN && ev && v < int'(m_acc);
    if (m_wrap) m_epoch = m_epoch + 8'd1;
    if (ev && m_valid && !rdy) m_orun = 1;
    else if (clr) m_orun = 0;
    m_valid = ev ? 1'b1 : (m_valid && rdy) ? 1'b0 : m_valid;
    if (ev) begin
      m_count = {m_epoch, 3'(v)};
      m_acc = 3'(v);
    end
    x.push_back(int'(c));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] c, input logic rdy, input logic clr);
    rst = r; cnt_in = c; out_ready = rdy; clr_overrun = clr;
    model(r, c, rdy, clr);
    @(posedge clk);
    #1;
    chk("m_valid", 32'(out_valid), 32'(m_valid));
    chk("m_count", 32'(out_count), 32'(m_count));
    chk("m_wrap", 32'(wrap_pulse), 32'(m_wrap));
    chk("m_overrun", 32'(overrun), 32'(m_orun));
  endtask

  typedef struct {
    logic r; logic [2:0] c; logic rdy; logic clr;
    logic ev; logic [10:0] ec; logic eo;
  } vec_t;
  vec_t tv[$];

  initial begin
    int transfers, wraps, hold;
    logic [10:0] last;
    logic [2:0] v;
    // basic latency and handshake
    tv.push_back('{1, 0, 1, 0, 0, 0, 0});
    repeat (4) tv.push_back('{0, 3, 1, 0, 0, 0, 0});
    tv.push_back('{0, 3, 1, 0, 1, 3, 0});
    repeat (2) tv.push_back('{0, 3, 1, 0, 0, 3, 0});
    // single-cycle glitch is rejected
    tv.push_back('{1, 0, 1, 0, 0, 0, 0});
    tv.push_back('{0, 5, 1, 0, 0, 0, 0});
    repeat (6) tv.push_back('{0, 0, 1, 0, 0, 0, 0});
    // overrun with consumer stalled, clear, then reset mid-handshake
    tv.push_back('{1, 0, 0, 0, 0, 0, 0});
    repeat (4) tv.push_back('{0, 1, 0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 1, 1, 0});
    repeat (4) tv.push_back('{0, 2, 0, 0, 1, 1, 0});
    repeat (2) tv.push_back('{0, 2, 0, 0, 1, 2, 1});
    tv.push_back('{0, 2, 0, 1, 1, 2, 0});
    tv.push_back('{1, 2, 0, 0, 0, 0, 0});
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].c, tv[i].rdy, tv[i].clr);
      chk("tv_valid", 32'(out_valid), 32'(tv[i].ev));
      chk("tv_count", 32'(out_count), 32'(tv[i].ec));
      chk("tv_overrun", 32'(overrun), 32'(tv[i].eo));
      chk("tv_wrap", 32'(wrap_pulse), 32'd0);
    end

    // full sweep 0..7 then back to 0
    step(1, 0, 1, 0);
    transfers = 0; wraps = 0; last = '0;
    for (int k = 0; k <= 8; k++) begin
      v = 3'(k);
      repeat (8) begin
        step(0, v, 1, 0);
        if (out_valid) begin transfers++; last = out_count; end
        if (wrap_pulse) wraps++;
      end
    end
    chk("sweep_transfers", 32'(transfers), 32'd8);
    chk("sweep_last", 32'(last), WRAP_EN ? 32'd8 : 32'd0);
    chk("sweep_wraps", 32'(wraps), WRAP_EN ? 32'd1 : 32'd0);

    // randomized segments
    step(1, 0, 1, 0);
    for (int s = 0; s < 400; s++) begin
      v = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++)
        step($urandom_range(0, 199) == 0, v, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
